// File: rtl/date_pkg.sv
// Shared constants and state encoding for the calendar date counter.
package date_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    localparam int DOY_W = 9;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/date_counter_month_length.sv
// Combinational days-per-month lookup; February follows the leap select.
module month_length
    import date_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] length
);

    always_comb begin
        length = 5'd31;
        case (month)
            FEB:               length = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: length = 5'd30;
            default:           length = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Calendar day counter: month, BCD day-of-month and day-of-year advanced by tick.
// Optional macro BLANK_LEADING_ZERO_EN blanks a zero tens digit on day_tens.
module date_counter
    import date_pkg::*;
#(
    parameter int LAST_MONTH = 4,
    parameter bit WRAP       = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             hold,
    input  logic             leap,
    output logic [3:0]       month,
    output logic [3:0]       day_tens,
    output logic [3:0]       day_ones,
    output logic [DOY_W-1:0] day_of_year,
    output logic             year_wrap,
    output logic             done
);

    state_t           state;
    logic [3:0]       month_q;
    logic [3:0]       tens_q;
    logic [3:0]       tens_disp;
    logic [3:0]       ones_q;
    logic [DOY_W-1:0] doy_q;
    logic             year_wrap_q;
    logic             done_q;

    logic [4:0] month_len;
    logic [5:0] dom;
    logic       month_end;
    logic       last_month;

    month_length u_month_length (
        .month  (month_q),
        .leap   (leap),
        .length (month_len)
    );

    // >= rather than == so a Feb 29 left behind by a leap drop still rolls over.
    assign dom        = 6'(tens_q) * 6'd10 + 6'(ones_q);
    assign month_end  = dom >= {1'b0, month_len};
    assign last_month = month_q == 4'(LAST_MONTH);

    function automatic logic [3:0] show_tens(input logic [3:0] t);
`ifdef BLANK_LEADING_ZERO_EN
        return (t == 4'd0) ? BLANK_DIGIT : t;
`else
        return t;
`endif
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            month_q     <= JAN;
            tens_q      <= 4'd0;
            tens_disp   <= show_tens(4'd0);
            ones_q      <= 4'd1;
            doy_q       <= DOY_W'(1);
            year_wrap_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            year_wrap_q <= 1'b0;
            case (state)
                RUN: begin
                    if (hold) begin
                        state <= PAUSE;
                    end else if (tick) begin
                        if (month_end) begin
                            if (last_month) begin
                                if (WRAP) begin
                                    month_q     <= JAN;
                                    tens_q      <= 4'd0;
                                    tens_disp   <= show_tens(4'd0);
                                    ones_q      <= 4'd1;
                                    doy_q       <= DOY_W'(1);
                                    year_wrap_q <= 1'b1;
                                end else begin
                                    state  <= DONE;
                                    done_q <= 1'b1;
                                end
                            end else begin
                                month_q   <= month_q + 4'd1;
                                tens_q    <= 4'd0;
                                tens_disp <= show_tens(4'd0);
                                ones_q    <= 4'd1;
                                doy_q     <= doy_q + DOY_W'(1);
                            end
                        end else begin
                            if (ones_q == 4'd9) begin
                                ones_q    <= 4'd0;
                                tens_q    <= tens_q + 4'd1;
                                tens_disp <= show_tens(tens_q + 4'd1);
                            end else begin
                                ones_q <= ones_q + 4'd1;
                            end
                            doy_q <= doy_q + DOY_W'(1);
                        end
                    end
                end
                // Ticks seen while paused are discarded, including on the release cycle.
                PAUSE: begin
                    if (!hold) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign month       = month_q;
    assign day_tens    = tens_disp;
    assign day_ones    = ones_q;
    assign day_of_year = doy_q;
    assign year_wrap   = year_wrap_q;
    assign done        = done_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: a wrapping and a stopping instance share stimulus.
module tb_date_counter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tick  = 1'b0;
    logic hold  = 1'b0;
    logic leap  = 1'b0;

    logic [3:0] w_month, w_day_tens, w_day_ones;
    logic [8:0] w_day_of_year;
    logic       w_year_wrap, w_done;
    logic [3:0] s_month, s_day_tens, s_day_ones;
    logic [8:0] s_day_of_year;
    logic       s_year_wrap, s_done;

    logic [20:0] w_date, s_date;
    assign w_date = {w_month, w_day_tens, w_day_ones, w_day_of_year};
    assign s_date = {s_month, s_day_tens, s_day_ones, s_day_of_year};

    int checks   = 0;
    int failures = 0;

    always #50 clock = ~clock;

    date_counter #(.LAST_MONTH(4), .WRAP(1'b1)) dut_w (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .hold        (hold),
        .leap        (leap),
        .month       (w_month),
        .day_tens    (w_day_tens),
        .day_ones    (w_day_ones),
        .day_of_year (w_day_of_year),
        .year_wrap   (w_year_wrap),
        .done        (w_done)
    );

    date_counter #(.LAST_MONTH(4), .WRAP(1'b0)) dut_s (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .hold        (hold),
        .leap        (leap),
        .month       (s_month),
        .day_tens    (s_day_tens),
        .day_ones    (s_day_ones),
        .day_of_year (s_day_of_year),
        .year_wrap   (s_year_wrap),
        .done        (s_done)
    );

    function automatic logic [3:0] exp_tens(input logic [3:0] t);
`ifdef BLANK_LEADING_ZERO_EN
        return (t == 4'd0) ? 4'hF : t;
`else
        return t;
`endif
    endfunction

    function automatic logic [20:0] date(input logic [3:0] m, input logic [3:0] t,
                                         input logic [3:0] o, input logic [8:0] d);
        return {m, exp_tens(t), o, d};
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        #10;
        reset = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clock);
        tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) do_tick();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL reset_date_w: got %h required %h", w_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        checks++;
        if (s_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL reset_date_s: got %h required %h", s_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        checks++;
        if ({w_year_wrap, w_done, s_year_wrap, s_done} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b required 0000", {w_year_wrap, w_done, s_year_wrap, s_done});
        end
    endtask

    task automatic test_january();
        leap = 1'b0;
        apply_reset();
        tick_n(30);
        checks++;
        if (w_date !== date(4'd1, 4'd3, 4'd1, 9'd31)) begin
            failures++; $display("FAIL jan31: got %h required %h", w_date, date(4'd1, 4'd3, 4'd1, 9'd31));
        end
        do_tick();
        checks++;
        if (w_date !== date(4'd2, 4'd0, 4'd1, 9'd32)) begin
            failures++; $display("FAIL feb1: got %h required %h", w_date, date(4'd2, 4'd0, 4'd1, 9'd32));
        end
        checks++;
        if (s_date !== date(4'd2, 4'd0, 4'd1, 9'd32)) begin
            failures++; $display("FAIL feb1_s: got %h required %h", s_date, date(4'd2, 4'd0, 4'd1, 9'd32));
        end
    endtask

    task automatic test_leap();
        leap = 1'b1;
        apply_reset();
        tick_n(59);
        checks++;
        if (w_date !== date(4'd2, 4'd2, 4'd9, 9'd60)) begin
            failures++; $display("FAIL leap_feb29: got %h required %h", w_date, date(4'd2, 4'd2, 4'd9, 9'd60));
        end
        do_tick();
        checks++;
        if (w_date !== date(4'd3, 4'd0, 4'd1, 9'd61)) begin
            failures++; $display("FAIL leap_mar1: got %h required %h", w_date, date(4'd3, 4'd0, 4'd1, 9'd61));
        end
        leap = 1'b0;
        apply_reset();
        tick_n(58);
        checks++;
        if (w_date !== date(4'd2, 4'd2, 4'd8, 9'd59)) begin
            failures++; $display("FAIL common_feb28: got %h required %h", w_date, date(4'd2, 4'd2, 4'd8, 9'd59));
        end
        do_tick();
        checks++;
        if (w_date !== date(4'd3, 4'd0, 4'd1, 9'd60)) begin
            failures++; $display("FAIL common_mar1: got %h required %h", w_date, date(4'd3, 4'd0, 4'd1, 9'd60));
        end
    endtask

    task automatic test_leap_drop();
        leap = 1'b1;
        apply_reset();
        tick_n(59);
        @(negedge clock);
        leap = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (w_date !== date(4'd2, 4'd2, 4'd9, 9'd60)) begin
            failures++; $display("FAIL drop_hold29: got %h required %h", w_date, date(4'd2, 4'd2, 4'd9, 9'd60));
        end
        do_tick();
        checks++;
        if (w_date !== date(4'd3, 4'd0, 4'd1, 9'd61)) begin
            failures++; $display("FAIL drop_mar1: got %h required %h", w_date, date(4'd3, 4'd0, 4'd1, 9'd61));
        end
    endtask

    task automatic test_wrap_done();
        leap = 1'b0;
        apply_reset();
        tick_n(119);
        checks++;
        if (w_date !== date(4'd4, 4'd3, 4'd0, 9'd120)) begin
            failures++; $display("FAIL apr30_w: got %h required %h", w_date, date(4'd4, 4'd3, 4'd0, 9'd120));
        end
        checks++;
        if (s_date !== date(4'd4, 4'd3, 4'd0, 9'd120)) begin
            failures++; $display("FAIL apr30_s: got %h required %h", s_date, date(4'd4, 4'd3, 4'd0, 9'd120));
        end
        do_tick();
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL wrap_jan1: got %h required %h", w_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        checks++;
        if ({w_year_wrap, w_done} !== 2'b10) begin
            failures++; $display("FAIL wrap_pulse: got %b required 10", {w_year_wrap, w_done});
        end
        checks++;
        if ({s_done, s_year_wrap} !== 2'b10) begin
            failures++; $display("FAIL stop_done: got %b required 10", {s_done, s_year_wrap});
        end
        checks++;
        if (s_date !== date(4'd4, 4'd3, 4'd0, 9'd120)) begin
            failures++; $display("FAIL stop_frozen: got %h required %h", s_date, date(4'd4, 4'd3, 4'd0, 9'd120));
        end
        @(posedge clock);
        #1;
        checks++;
        if (w_year_wrap !== 1'b0) begin
            failures++; $display("FAIL wrap_one_cycle: got %b required 0", w_year_wrap);
        end
        tick_n(5);
        checks++;
        if (s_date !== date(4'd4, 4'd3, 4'd0, 9'd120) || s_done !== 1'b1) begin
            failures++; $display("FAIL done_ignores_ticks: got %h/%b required %h/1", s_date, s_done, date(4'd4, 4'd3, 4'd0, 9'd120));
        end
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd6, 9'd6)) begin
            failures++; $display("FAIL after_wrap_jan6: got %h required %h", w_date, date(4'd1, 4'd0, 4'd6, 9'd6));
        end
        apply_reset();
        #1;
        checks++;
        if (s_date !== date(4'd1, 4'd0, 4'd1, 9'd1) || s_done !== 1'b0) begin
            failures++; $display("FAIL done_reset: got %h/%b required %h/0", s_date, s_done, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
    endtask

    task automatic test_hold();
        leap = 1'b0;
        apply_reset();
        @(negedge clock);
        hold = 1'b1;
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        tick_n(9);
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL hold_frozen: got %h required %h", w_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        @(negedge clock);
        hold = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL hold_no_queue: got %h required %h", w_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        do_tick();
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd2, 9'd2)) begin
            failures++; $display("FAIL hold_release: got %h required %h", w_date, date(4'd1, 4'd0, 4'd2, 9'd2));
        end
        @(posedge clock);
        #1;
        checks++;
        if (s_date !== date(4'd1, 4'd0, 4'd2, 9'd2)) begin
            failures++; $display("FAIL hold_release_s: got %h required %h", s_date, date(4'd1, 4'd0, 4'd2, 9'd2));
        end
    endtask

    task automatic test_async_reset();
        leap = 1'b0;
        apply_reset();
        tick_n(73);
        checks++;
        if (w_date !== date(4'd3, 4'd1, 4'd5, 9'd74)) begin
            failures++; $display("FAIL mar15: got %h required %h", w_date, date(4'd3, 4'd1, 4'd5, 9'd74));
        end
        #24;
        reset = 1'b1;
        #5;
        checks++;
        if (w_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL async_reset_w: got %h required %h", w_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        checks++;
        if (s_date !== date(4'd1, 4'd0, 4'd1, 9'd1)) begin
            failures++; $display("FAIL async_reset_s: got %h required %h", s_date, date(4'd1, 4'd0, 4'd1, 9'd1));
        end
        #5;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_january();
        test_leap();
        test_leap_drop();
        test_wrap_done();
        test_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
